// File: rtl/mem_bus_pkg.sv
`default_nettype none
// ============================================================================
// mem_bus_pkg: shared types for the fetch/load-store memory port arbiter.
// Rev 1.0
// ============================================================================
package mem_bus_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      RD     = 3'd1,
      WR     = 3'd2,
      RMW_RD = 3'd3,
      RMW_WR = 3'd4
   } state_t;

   typedef enum logic {
      GNT_IF = 1'b0,
      GNT_D  = 1'b1
   } gnt_t;

   localparam logic [3:0] BE_FULL = 4'hF;

endpackage
`default_nettype wire

// File: rtl/byte_merge.sv
`default_nettype none
// ============================================================================
// byte_merge: per-byte select between new store data and the word read back.
// Rev 1.0
// ============================================================================
module byte_merge (
   input  logic [3:0]  i_be,
   input  logic [31:0] i_new,
   input  logic [31:0] i_old,
   output logic [31:0] o_merged
);

   genvar n;
   generate
      for (n = 0; n < 4; n++) begin : g_lane
         assign o_merged[8*n +: 8] = i_be[n] ? i_new[8*n +: 8] : i_old[8*n +: 8];
      end
   endgenerate

endmodule
`default_nettype wire

// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// mem_bus_arbiter: shares one word-wide memory port between fetch and data.
// Rev 1.0
// ============================================================================
module mem_bus_arbiter
   import mem_bus_pkg::*;
#(
   parameter int DATA_PRIORITY = 1,
   parameter int ADDR_W        = 32
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_if_req,
   input  logic [ADDR_W-1:0] i_if_addr,
   output logic              o_if_ack,
   output logic [31:0]       o_if_rdata,
   input  logic              i_d_req,
   input  logic              i_d_we,
   input  logic [3:0]        i_d_be,
   input  logic [ADDR_W-1:0] i_d_addr,
   input  logic [31:0]       i_d_wdata,
   output logic              o_d_ack,
   output logic [31:0]       o_d_rdata,
   output logic              o_busy,
   output logic [ADDR_W-1:0] o_memaddr,
   output logic              o_memread,
   inout  wire  [31:0]       b_membus
);

   state_t            state_q, state_d;
   gnt_t              gnt_q, gnt_d;
   gnt_t              last_q, last_d;
   gnt_t              w_pick;
   logic [ADDR_W-1:0] memaddr_q, memaddr_d;
   logic              memread_q, memread_d;
   logic [3:0]        be_q, be_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [31:0]       merge_q, merge_d;
   logic [31:0]       if_rdata_q, if_rdata_d;
   logic [31:0]       d_rdata_q, d_rdata_d;
   logic              if_ack_q, if_ack_d;
   logic              d_ack_q, d_ack_d;
   logic              w_if_ok, w_d_ok;
   logic [31:0]       w_merged;
   logic [31:0]       w_bus_out;
   logic              unused_addr_bits;

   assign unused_addr_bits = ^{i_if_addr[1:0], i_d_addr[1:0]};

   byte_merge u_byte_merge (
      .i_be     (be_q),
      .i_new    (wdata_q),
      .i_old    (merge_q),
      .o_merged (w_merged)
   );

   // Driver enable is the registered o_memread itself, so bus ownership flips with it.
   assign w_bus_out = (state_q == RMW_WR) ? w_merged : wdata_q;
   assign b_membus  = memread_q ? {32{1'bz}} : w_bus_out;

   // A port whose ack is showing this cycle has already been served.
   always_comb begin
      w_if_ok = i_if_req & ~if_ack_q;
      w_d_ok  = i_d_req & ~d_ack_q;
      if (w_if_ok && w_d_ok)
         w_pick = ((DATA_PRIORITY != 0) || (last_q == GNT_IF)) ? GNT_D : GNT_IF;
      else if (w_d_ok)
         w_pick = GNT_D;
      else
         w_pick = GNT_IF;
   end

   always_comb begin
      state_d    = state_q;
      gnt_d      = gnt_q;
      last_d     = last_q;
      memaddr_d  = memaddr_q;
      memread_d  = 1'b1;
      be_d       = be_q;
      wdata_d    = wdata_q;
      merge_d    = merge_q;
      if_rdata_d = if_rdata_q;
      d_rdata_d  = d_rdata_q;
      if_ack_d   = 1'b0;
      d_ack_d    = 1'b0;
      case (state_q)
         IDLE: begin
            if (w_if_ok || w_d_ok) begin
               gnt_d  = w_pick;
               last_d = w_pick;
               if (w_pick == GNT_IF) begin
                  memaddr_d = {i_if_addr[ADDR_W-1:2], 2'b00};
                  state_d   = RD;
               end else begin
                  memaddr_d = {i_d_addr[ADDR_W-1:2], 2'b00};
                  be_d      = i_d_be;
                  wdata_d   = i_d_wdata;
                  if (!i_d_we) begin
                     state_d = RD;
                  end else if (i_d_be == BE_FULL) begin
                     state_d   = WR;
                     memread_d = 1'b0;
                  end else if (i_d_be == 4'h0) begin
                     d_ack_d = 1'b1;
                  end else begin
                     state_d = RMW_RD;
                  end
               end
            end
         end
         RD: begin
            state_d = IDLE;
            if (gnt_q == GNT_IF) begin
               if_rdata_d = b_membus;
               if_ack_d   = 1'b1;
            end else begin
               d_rdata_d = b_membus;
               d_ack_d   = 1'b1;
            end
         end
         RMW_RD: begin
            merge_d   = b_membus;
            state_d   = RMW_WR;
            memread_d = 1'b0;
         end
         WR, RMW_WR: begin
            state_d = IDLE;
            d_ack_d = 1'b1;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state_q    <= IDLE;
         gnt_q      <= GNT_D;
         last_q     <= GNT_D;
         memaddr_q  <= '0;
         memread_q  <= 1'b1;
         be_q       <= 4'h0;
         wdata_q    <= 32'h0;
         merge_q    <= 32'h0;
         if_rdata_q <= 32'h0;
         d_rdata_q  <= 32'h0;
         if_ack_q   <= 1'b0;
         d_ack_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         gnt_q      <= gnt_d;
         last_q     <= last_d;
         memaddr_q  <= memaddr_d;
         memread_q  <= memread_d;
         be_q       <= be_d;
         wdata_q    <= wdata_d;
         merge_q    <= merge_d;
         if_rdata_q <= if_rdata_d;
         d_rdata_q  <= d_rdata_d;
         if_ack_q   <= if_ack_d;
         d_ack_q    <= d_ack_d;
      end
   end

   assign o_if_ack   = if_ack_q;
   assign o_if_rdata = if_rdata_q;
   assign o_d_ack    = d_ack_q;
   assign o_d_rdata  = d_rdata_q;
   assign o_busy     = (state_q != IDLE);
   assign o_memaddr  = memaddr_q;
   assign o_memread  = memread_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// tb_mem_bus_arbiter: two arbiters (data priority / round robin) on word memories.
// Rev 1.0
// ============================================================================
module tb_mem_bus_arbiter;

   localparam logic [31:0] BASE = 32'h8000_0000;

   logic        clk;
   logic [1:0]  reset;
   logic [1:0]  if_req, d_req, d_we;
   logic [31:0] if_addr [2];
   logic [31:0] d_addr  [2];
   logic [31:0] d_wdata [2];
   logic [3:0]  d_be    [2];
   wire  [1:0]  if_ack, d_ack, busy, memread;
   wire  [31:0] if_rdata [2];
   wire  [31:0] d_rdata  [2];
   wire  [31:0] memaddr  [2];
   wire  [31:0] bus0, bus1;

   logic [31:0] mem     [2][64];
   logic [31:0] ref_mem [2][64];
   int          falls   [2];
   int          exp_last [2];   // 1 = data port granted last
   int          n_cmp, n_bad;
   bit          mon_en;

   mem_bus_arbiter #(.DATA_PRIORITY(1), .ADDR_W(32)) u_dut0 (
      .i_clk(clk), .i_reset(reset[0]),
      .i_if_req(if_req[0]), .i_if_addr(if_addr[0]), .o_if_ack(if_ack[0]), .o_if_rdata(if_rdata[0]),
      .i_d_req(d_req[0]), .i_d_we(d_we[0]), .i_d_be(d_be[0]), .i_d_addr(d_addr[0]),
      .i_d_wdata(d_wdata[0]), .o_d_ack(d_ack[0]), .o_d_rdata(d_rdata[0]), .o_busy(busy[0]),
      .o_memaddr(memaddr[0]), .o_memread(memread[0]), .b_membus(bus0)
   );

   mem_bus_arbiter #(.DATA_PRIORITY(0), .ADDR_W(32)) u_dut1 (
      .i_clk(clk), .i_reset(reset[1]),
      .i_if_req(if_req[1]), .i_if_addr(if_addr[1]), .o_if_ack(if_ack[1]), .o_if_rdata(if_rdata[1]),
      .i_d_req(d_req[1]), .i_d_we(d_we[1]), .i_d_be(d_be[1]), .i_d_addr(d_addr[1]),
      .i_d_wdata(d_wdata[1]), .o_d_ack(d_ack[1]), .o_d_rdata(d_rdata[1]), .o_busy(busy[1]),
      .o_memaddr(memaddr[1]), .o_memread(memread[1]), .b_membus(bus1)
   );

   function automatic int widx(logic [31:0] a);
      logic [31:0] off;
      off = (a - BASE) >> 2;
      return int'(off[5:0]);
   endfunction

   function automatic logic [31:0] merge(logic [3:0] be, logic [31:0] nw, logic [31:0] old);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++)
         if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
      return r;
   endfunction

   // Memory: drives the bus while o_memread is high, takes the bus while it is low.
   assign bus0 = memread[0] ? mem[0][widx(memaddr[0])] : {32{1'bz}};
   assign bus1 = memread[1] ? mem[1][widx(memaddr[1])] : {32{1'bz}};

   always @(negedge clk) begin
      if (memread[0] === 1'b0) mem[0][widx(memaddr[0])] <= bus0;
      if (memread[1] === 1'b0) mem[1][widx(memaddr[1])] <= bus1;
   end

   always @(negedge memread[0]) falls[0]++;
   always @(negedge memread[1]) falls[1]++;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: observed %h, expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         chk("ack_onehot0", {31'h0, if_ack[0] & d_ack[0]}, 32'h0);
         chk("ack_onehot1", {31'h0, if_ack[1] & d_ack[1]}, 32'h0);
         if (memread[0]) chk("bus_owner0", bus0, mem[0][widx(memaddr[0])]);
         if (memread[1]) chk("bus_owner1", bus1, mem[1][widx(memaddr[1])]);
      end
   end

   // kind: 0 fetch, 1 load, 2 store
   task automatic single(int u, int kind, logic [31:0] addr, logic [3:0] be, logic [31:0] wd);
      int          idx, f0, lat, exp_lat;
      bit          got;
      logic [31:0] old, seen;
      idx = widx(addr);
      old = ref_mem[u][idx];
      f0  = falls[u];
      lat = 0;
      got = 0;
      seen = 32'h0;
      if (kind == 0) begin
         if_req[u] = 1'b1; if_addr[u] = addr;
      end else begin
         d_req[u] = 1'b1; d_we[u] = (kind == 2); d_addr[u] = addr; d_be[u] = be; d_wdata[u] = wd;
      end
      exp_lat = (kind < 2) ? 2 : (be == 4'h0) ? 1 : (be == 4'hF) ? 2 : 3;
      while (!got && lat < 12) begin
         tick();
         lat++;
         if ((kind == 0) ? if_ack[u] : d_ack[u]) begin
            got  = 1;
            seen = (kind == 0) ? if_rdata[u] : d_rdata[u];
         end
      end
      if_req[u] = 1'b0;
      d_req[u]  = 1'b0;
      chk("ack_seen", {31'h0, got}, 32'h1);
      chk("latency", lat, exp_lat);
      if (kind < 2) begin
         chk("rdata", seen, old);
      end else begin
         ref_mem[u][idx] = merge(be, wd, old);
         chk("mem_word", mem[u][idx], ref_mem[u][idx]);
      end
      chk("memread_falls", falls[u] - f0, (kind == 2 && be != 4'h0) ? 1 : 0);
      exp_last[u] = (kind == 0) ? 0 : 1;
      tick();
   endtask

   task automatic tie(int u, logic [31:0] faddr, logic [31:0] daddr, bit we,
                      logic [3:0] be, logic [31:0] wd);
      bit          win_d, gf, gd;
      int          fi, di, f_at, d_at, cyc;
      logic [31:0] f_exp, d_exp, f_seen, d_seen;
      win_d = (u == 0) || (exp_last[u] == 0);
      fi = widx(faddr);
      di = widx(daddr);
      if (win_d) begin
         d_exp = ref_mem[u][di];
         if (we) ref_mem[u][di] = merge(be, wd, ref_mem[u][di]);
         f_exp = ref_mem[u][fi];
      end else begin
         f_exp = ref_mem[u][fi];
         d_exp = ref_mem[u][di];
         if (we) ref_mem[u][di] = merge(be, wd, ref_mem[u][di]);
      end
      if_req[u] = 1'b1; if_addr[u] = faddr;
      d_req[u] = 1'b1; d_we[u] = we; d_addr[u] = daddr; d_be[u] = be; d_wdata[u] = wd;
      gf = 0; gd = 0; f_at = 99; d_at = 99; cyc = 0;
      f_seen = 32'h0; d_seen = 32'h0;
      while (!(gf && gd) && cyc < 20) begin
         tick();
         cyc++;
         if (if_ack[u] && !gf) begin gf = 1; f_at = cyc; f_seen = if_rdata[u]; if_req[u] = 1'b0; end
         if (d_ack[u] && !gd)  begin gd = 1; d_at = cyc; d_seen = d_rdata[u];  d_req[u] = 1'b0; end
      end
      if_req[u] = 1'b0;
      d_req[u]  = 1'b0;
      chk("tie_if_ack", {31'h0, gf}, 32'h1);
      chk("tie_d_ack", {31'h0, gd}, 32'h1);
      chk("tie_data_first", {31'h0, d_at < f_at}, {31'h0, win_d});
      chk("tie_if_rdata", f_seen, f_exp);
      if (!we) chk("tie_d_rdata", d_seen, d_exp);
      else     chk("tie_mem_word", mem[u][di], ref_mem[u][di]);
      exp_last[u] = win_d ? 0 : 1;
      tick();
   endtask

   function automatic logic [31:0] rnd_addr();
      return BASE + 32'($urandom_range(0, 15) * 4) + 32'($urandom_range(0, 3));
   endfunction

   function automatic logic [3:0] rnd_be();
      int s;
      s = int'($urandom_range(0, 3));
      if (s == 0) return 4'h0;
      if (s == 1) return 4'hF;
      return 4'($urandom_range(1, 14));
   endfunction

   initial begin
      int          f0, r;
      bit          ack_seen;
      logic [31:0] old;
      n_cmp = 0; n_bad = 0; mon_en = 0;
      falls[0] = 0; falls[1] = 0;
      exp_last[0] = 1; exp_last[1] = 1;
      if_req = '0; d_req = '0; d_we = '0;
      for (int u = 0; u < 2; u++) begin
         if_addr[u] = 32'h0; d_addr[u] = 32'h0; d_wdata[u] = 32'h0; d_be[u] = 4'h0;
         for (int k = 0; k < 64; k++) begin
            mem[u][k]     = 32'h1111_0000 + 32'(k);
            ref_mem[u][k] = 32'h1111_0000 + 32'(k);
         end
      end
      reset = 2'b11;
      repeat (3) tick();
      for (int u = 0; u < 2; u++) begin
         chk("rst_memread", {31'h0, memread[u]}, 32'h1);
         chk("rst_busy", {31'h0, busy[u]}, 32'h0);
         chk("rst_acks", {30'h0, if_ack[u], d_ack[u]}, 32'h0);
         chk("rst_if_rdata", if_rdata[u], 32'h0);
         chk("rst_d_rdata", d_rdata[u], 32'h0);
         chk("rst_memaddr", memaddr[u], 32'h0);
      end
      f0 = falls[0] + falls[1];
      reset = 2'b00;
      tick();
      chk("rst_release_falls", falls[0] + falls[1] - f0, 0);
      mon_en = 1;

      // Directed scenarios
      single(0, 0, 32'h8000_0008, 4'h0, 32'h0);
      chk("fetch_word2", ref_mem[0][2], 32'h1111_0002);
      single(0, 2, 32'h8000_0010, 4'hF, 32'hDEAD_BEEF);
      single(0, 1, 32'h8000_0010, 4'h0, 32'h0);
      chk("full_store_word", mem[0][4], 32'hDEAD_BEEF);
      single(0, 2, 32'h8000_0014, 4'b0010, 32'h0000_AB00);
      chk("rmw_word", mem[0][5], 32'h1111_AB05);
      single(0, 2, 32'h8000_0020, 4'h0, 32'hFFFF_FFFF);
      for (int i = 0; i < 3; i++) tie(0, 32'h8000_0030, 32'h8000_0034, 1'b0, 4'h0, 32'h0);
      single(1, 0, 32'h8000_0004, 4'h0, 32'h0);
      for (int i = 0; i < 3; i++) tie(1, 32'h8000_0030, 32'h8000_0034 + 32'(4 * i), 1'b0, 4'h0, 32'h0);
      tie(1, 32'h8000_0008, 32'h8000_0008, 1'b1, 4'b1001, 32'hA500_005A);

      // Reset while the read half of a read-modify-write is in flight
      old = ref_mem[0][6];
      f0  = falls[0];
      d_req[0] = 1'b1; d_we[0] = 1'b1; d_be[0] = 4'b0010;
      d_addr[0] = 32'h8000_0018; d_wdata[0] = 32'h0000_CD00;
      @(posedge clk);
      #2;
      chk("rmw_rd_busy", {31'h0, busy[0]}, 32'h1);
      chk("rmw_rd_memread", {31'h0, memread[0]}, 32'h1);
      reset[0] = 1'b1;
      #1;
      chk("abort_memread", {31'h0, memread[0]}, 32'h1);
      chk("abort_busy", {31'h0, busy[0]}, 32'h0);
      d_req[0] = 1'b0;
      ack_seen = 0;
      repeat (3) begin tick(); if (d_ack[0]) ack_seen = 1; end
      reset[0] = 1'b0;
      repeat (2) begin tick(); if (d_ack[0]) ack_seen = 1; end
      chk("abort_no_ack", {31'h0, ack_seen}, 32'h0);
      chk("abort_word", mem[0][6], old);
      chk("abort_falls", falls[0] - f0, 0);
      chk("abort_rdata", d_rdata[0], 32'h0);
      exp_last[0] = 1;
      single(0, 0, 32'h8000_0018, 4'h0, 32'h0);

      // Randomized traffic against the reference memory
      for (int u = 0; u < 2; u++) begin
         for (int n = 0; n < 120; n++) begin
            r = int'($urandom_range(0, 9));
            if (r < 3)      single(u, 0, rnd_addr(), 4'h0, 32'h0);
            else if (r < 5) single(u, 1, rnd_addr(), 4'h0, 32'h0);
            else if (r < 8) single(u, 2, rnd_addr(), rnd_be(), $urandom);
            else            tie(u, rnd_addr(), rnd_addr(), 1'($urandom_range(0, 1)), rnd_be(), $urandom);
         end
      end

      for (int u = 0; u < 2; u++)
         for (int k = 0; k < 16; k++)
            chk("final_mem", mem[u][k], ref_mem[u][k]);

      mon_en = 0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
